// File: rtl/rcosc_freq_monitor.sv
//-----------------------------------------------------------------------------
// rcosc_freq_monitor
//
// Frequency monitor for the 100 kHz RC oscillator. It enables the oscillator,
// synchronizes its clock into the clk domain, discards a few start-up edges,
// then counts clk cycles across WINDOW oscillator periods. Each result is
// compared against programmable limits and offered through a valid/ack
// handshake. An oscillator that stops toggling is reported as dead after
// TIMEOUT clk cycles without an edge.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset
//   enable      monitor enable; low returns to IDLE and turns the oscillator off
//   osc_en      oscillator EN pin
//   osc_clk     oscillator clock, asynchronous to clk
//   lo_limit    minimum acceptable meas_count
//   hi_limit    maximum acceptable meas_count
//   meas_valid  result available
//   meas_ack    consumer accepts result (ignored while meas_valid is low)
//   meas_count  clk cycles spanning WINDOW oscillator periods (0 on dead)
//   fault_slow  meas_count > hi_limit
//   fault_fast  meas_count < lo_limit
//   fault_dead  no oscillator edge for TIMEOUT clk cycles
//   irq         (only with RCOSC_FREQ_MONITOR_IRQ_EN) a faulty result is
//               waiting for acknowledgement
//
// Optional feature macro: RCOSC_FREQ_MONITOR_IRQ_EN
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module rcosc_freq_monitor #(
   parameter int CNT_W        = 24,
   parameter int WINDOW       = 4,
   parameter int SETTLE_EDGES = 2,
   parameter int TIMEOUT      = 4096,
   parameter int SYNC_STAGES  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic             osc_en,
   input  logic             osc_clk,
   input  logic [CNT_W-1:0] lo_limit,
   input  logic [CNT_W-1:0] hi_limit,
   output logic             meas_valid,
   input  logic             meas_ack,
   output logic [CNT_W-1:0] meas_count,
   output logic             fault_slow,
   output logic             fault_fast,
   output logic             fault_dead
`ifdef RCOSC_FREQ_MONITOR_IRQ_EN
   ,
   output logic             irq
`endif
);

   localparam int SET_W = (SETTLE_EDGES < 1) ? 1 : $clog2(SETTLE_EDGES + 1);
   localparam int PER_W = $clog2(WINDOW + 1);
   localparam int TO_W  = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_ARM,
      S_MEASURE,
      S_REPORT
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic [SET_W-1:0]       settle_cnt_q, settle_cnt_d;
   logic [PER_W-1:0]       per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0]       cyc_cnt_q, cyc_cnt_d;
   logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
   logic                   osc_en_q, osc_en_d;
   logic                   valid_q, valid_d;
   logic [CNT_W-1:0]       meas_count_q, meas_count_d;
   logic                   fault_slow_q, fault_slow_d;
   logic                   fault_fast_q, fault_fast_d;
   logic                   fault_dead_q, fault_dead_d;
`ifdef RCOSC_FREQ_MONITOR_IRQ_EN
   logic                   irq_q, irq_d;
`endif

   logic             rise;
   logic             to_active;
   logic             timeout_hit;
   logic             go_dead;
   logic             capture;
   logic [SET_W-1:0] settle_inc;
   logic [PER_W-1:0] per_inc;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      per_cnt_d    = per_cnt_q;
      cyc_cnt_d    = cyc_cnt_q;
      osc_en_d     = osc_en_q;
      valid_d      = valid_q;
      meas_count_d = meas_count_q;
      fault_slow_d = fault_slow_q;
      fault_fast_d = fault_fast_q;
      fault_dead_d = fault_dead_q;
      go_dead      = 1'b0;
      capture      = 1'b0;

      // Shift register synchronizer; the history flop follows the last stage
      // so a 0->1 step across them is one clean rising-edge pulse.
      sync_d = {sync_q[SYNC_STAGES-2:0], osc_clk};
      hist_d = sync_q[SYNC_STAGES-1];
      rise   = sync_q[SYNC_STAGES-1] & ~hist_q;

      settle_inc = settle_cnt_q + 1'b1;
      per_inc    = per_cnt_q + 1'b1;

      // Edge watchdog: a rise always wins over the terminal count.
      to_active   = (state_q == S_SETTLE) || (state_q == S_ARM) || (state_q == S_MEASURE);
      timeout_hit = to_active && !rise && (to_cnt_q == TO_W'(TIMEOUT - 1));
      to_cnt_d    = (!to_active || rise) ? '0 : to_cnt_q + 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d      = S_SETTLE;
               osc_en_d     = 1'b1;
               settle_cnt_d = '0;
            end
         end
         S_SETTLE: begin
            if (SETTLE_EDGES == 0) begin
               state_d = S_ARM;
            end else if (rise) begin
               settle_cnt_d = settle_inc;
               if (settle_inc == SET_W'(SETTLE_EDGES)) state_d = S_ARM;
            end else if (timeout_hit) begin
               go_dead = 1'b1;
            end
         end
         S_ARM: begin
            // The start edge itself counts as cycle 1 of the span.
            if (rise) begin
               state_d   = S_MEASURE;
               cyc_cnt_d = CNT_W'(1);
               per_cnt_d = '0;
            end else if (timeout_hit) begin
               go_dead = 1'b1;
            end
         end
         S_MEASURE: begin
            cyc_cnt_d = (cyc_cnt_q == {CNT_W{1'b1}}) ? cyc_cnt_q : cyc_cnt_q + 1'b1;
            if (rise) begin
               per_cnt_d = per_inc;
               if (per_inc == PER_W'(WINDOW)) capture = 1'b1;
            end else if (timeout_hit) begin
               go_dead = 1'b1;
            end
         end
         S_REPORT: begin
            // Oscillator edges are ignored here; only the handshake moves on.
            if (meas_ack && valid_q) begin
               valid_d = 1'b0;
               state_d = S_ARM;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Pre-increment count is the exact cycle distance between the edges.
      if (capture) begin
         state_d      = S_REPORT;
         valid_d      = 1'b1;
         meas_count_d = cyc_cnt_q;
         fault_slow_d = cyc_cnt_q > hi_limit;
         fault_fast_d = cyc_cnt_q < lo_limit;
         fault_dead_d = 1'b0;
      end

      if (go_dead) begin
         state_d      = S_REPORT;
         valid_d      = 1'b1;
         meas_count_d = '0;
         fault_slow_d = 1'b0;
         fault_fast_d = 1'b0;
         fault_dead_d = 1'b1;
      end

      // Disabling abandons any measurement but keeps the last held result.
      if (!enable) begin
         state_d  = S_IDLE;
         osc_en_d = 1'b0;
         valid_d  = 1'b0;
      end

`ifdef RCOSC_FREQ_MONITOR_IRQ_EN
      // Raised while a faulty result waits; dropped by the handshake or disable.
      irq_d = enable && valid_q && !meas_ack &&
              (fault_slow_q || fault_fast_q || fault_dead_q);
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values computed in the same cycle regardless of order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         sync_q       <= '0;
         hist_q       <= 1'b0;
         settle_cnt_q <= '0;
         per_cnt_q    <= '0;
         cyc_cnt_q    <= '0;
         to_cnt_q     <= '0;
         osc_en_q     <= 1'b0;
         valid_q      <= 1'b0;
         meas_count_q <= '0;
         fault_slow_q <= 1'b0;
         fault_fast_q <= 1'b0;
         fault_dead_q <= 1'b0;
`ifdef RCOSC_FREQ_MONITOR_IRQ_EN
         irq_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         hist_q       <= hist_d;
         settle_cnt_q <= settle_cnt_d;
         per_cnt_q    <= per_cnt_d;
         cyc_cnt_q    <= cyc_cnt_d;
         to_cnt_q     <= to_cnt_d;
         osc_en_q     <= osc_en_d;
         valid_q      <= valid_d;
         meas_count_q <= meas_count_d;
         fault_slow_q <= fault_slow_d;
         fault_fast_q <= fault_fast_d;
         fault_dead_q <= fault_dead_d;
`ifdef RCOSC_FREQ_MONITOR_IRQ_EN
         irq_q        <= irq_d;
`endif
      end
   end

   assign osc_en     = osc_en_q;
   assign meas_valid = valid_q;
   assign meas_count = meas_count_q;
   assign fault_slow = fault_slow_q;
   assign fault_fast = fault_fast_q;
   assign fault_dead = fault_dead_q;
`ifdef RCOSC_FREQ_MONITOR_IRQ_EN
   assign irq        = irq_q;
`endif

endmodule

// File: tb/tb_rcosc_freq_monitor.sv
//-----------------------------------------------------------------------------
// tb_rcosc_freq_monitor
//
// Self-checking bench for rcosc_freq_monitor with default parameters.
// clk period 100 ns; the oscillator model produces a square wave whose period
// is an integer number of clk cycles, with edges offset from clk edges so the
// measured count is exactly WINDOW * period.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rcosc_freq_monitor;

   localparam int CNT_W   = 24;
   localparam int WINDOW  = 4;
   localparam int TIMEOUT = 4096;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic             osc_en;
   logic             osc_clk;
   logic [CNT_W-1:0] lo_limit;
   logic [CNT_W-1:0] hi_limit;
   logic             meas_valid;
   logic             meas_ack;
   logic [CNT_W-1:0] meas_count;
   logic             fault_slow;
   logic             fault_fast;
   logic             fault_dead;
`ifdef RCOSC_FREQ_MONITOR_IRQ_EN
   logic             irq;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int osc_half = 5000;
   bit osc_run  = 1'b0;

   typedef struct {
      string name;
      int    period;
      int    lo;
      int    hi;
      int    exp_count;
      bit    exp_slow;
      bit    exp_fast;
   } vec_t;

   vec_t vecs[6];

   rcosc_freq_monitor dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .osc_en     (osc_en),
      .osc_clk    (osc_clk),
      .lo_limit   (lo_limit),
      .hi_limit   (hi_limit),
      .meas_valid (meas_valid),
      .meas_ack   (meas_ack),
      .meas_count (meas_count),
      .fault_slow (fault_slow),
      .fault_fast (fault_fast),
      .fault_dead (fault_dead)
`ifdef RCOSC_FREQ_MONITOR_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   always #50 clk = ~clk;

   // Oscillator edges sit at 23 ns mod 50 ns, never on a clk edge.
   initial begin
      osc_clk = 1'b0;
      #23;
      forever begin
         if (osc_run) begin
            osc_clk = 1'b1;
            #(osc_half);
            osc_clk = 1'b0;
            #(osc_half);
         end else begin
            osc_clk = 1'b0;
            #50;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference: the span of WINDOW periods in clk cycles, saturating.
   function automatic int model_count(input int period);
      longint c;
      longint top;
      c   = longint'(WINDOW) * longint'(period);
      top = (longint'(1) << CNT_W) - 1;
      if (c > top) c = top;
      return int'(c);
   endfunction

   task automatic wait_valid(input int budget, output int cycles, output bit ok);
      cycles = 0;
      ok     = 1'b0;
      while (cycles < budget && !ok) begin
         @(negedge clk);
         cycles++;
         if (meas_valid === 1'b1) ok = 1'b1;
      end
   endtask

   // Disable, retune the oscillator, let it settle, then enable at a negedge.
   task automatic start_fresh(input int period, input int lo, input int hi);
      @(negedge clk);
      enable   = 1'b0;
      meas_ack = 1'b0;
      osc_half = period * 50;
      osc_run  = 1'b1;
      lo_limit = CNT_W'(lo);
      hi_limit = CNT_W'(hi);
      repeat (400) @(negedge clk);
      enable = 1'b1;
   endtask

   task automatic ack_and_check(input string name);
      meas_ack = 1'b1;
      @(negedge clk);
      meas_ack = 1'b0;
      check({name, "_valid_after_ack"}, 32'(meas_valid), 32'd0);
   endtask

   task automatic run_vec(input string name, input int period, input int lo, input int hi,
                          input int exp_cnt, input bit exp_slow, input bit exp_fast);
      int cyc;
      bit ok;
      start_fresh(period, lo, hi);
      wait_valid(12 * period + 200, cyc, ok);
      check({name, "_valid"}, 32'(ok), 32'd1);
      check({name, "_count"}, 32'(meas_count), 32'(exp_cnt));
      check({name, "_slow"},  32'(fault_slow), 32'(exp_slow));
      check({name, "_fast"},  32'(fault_fast), 32'(exp_fast));
      check({name, "_dead"},  32'(fault_dead), 32'd0);
      repeat (5) @(negedge clk);
      check({name, "_hold_valid"}, 32'(meas_valid), 32'd1);
      check({name, "_hold_count"}, 32'(meas_count), 32'(exp_cnt));
      ack_and_check(name);
   endtask

   initial begin
      int cyc;
      bit ok;
      int p, lo, hi, e;

      vecs[0] = '{"nominal",   100, 390, 410, 400, 1'b0, 1'b0};
      vecs[1] = '{"slow",      120, 390, 410, 480, 1'b1, 1'b0};
      vecs[2] = '{"fast",       80, 390, 410, 320, 1'b0, 1'b1};
      vecs[3] = '{"inverted",  100, 410, 390, 400, 1'b1, 1'b1};
      vecs[4] = '{"exact_lim", 100, 400, 400, 400, 1'b0, 1'b0};
      vecs[5] = '{"one_off",   100, 401, 399, 400, 1'b1, 1'b1};

      reset    = 1'b1;
      enable   = 1'b0;
      meas_ack = 1'b0;
      lo_limit = '0;
      hi_limit = '0;
      repeat (3) @(negedge clk);
      check("rst_osc_en", 32'(osc_en),     32'd0);
      check("rst_valid",  32'(meas_valid), 32'd0);
      check("rst_count",  32'(meas_count), 32'd0);
      check("rst_slow",   32'(fault_slow), 32'd0);
      check("rst_fast",   32'(fault_fast), 32'd0);
      check("rst_dead",   32'(fault_dead), 32'd0);
      reset = 1'b0;

      // First result: osc_en next cycle, then 2 settle + 1 arm + 4 edges.
      start_fresh(100, 390, 410);
      @(negedge clk);
      check("en_osc_en", 32'(osc_en), 32'd1);
      wait_valid(1400, cyc, ok);
      cyc++;
      check("first_valid", 32'(ok), 32'd1);
      check("first_latency_in_range", 32'(cyc >= 600 && cyc <= 708), 32'd1);
      check("first_count", 32'(meas_count), 32'd400);
      ack_and_check("first");

      foreach (vecs[i])
         run_vec(vecs[i].name, vecs[i].period, vecs[i].lo, vecs[i].hi,
                 vecs[i].exp_count, vecs[i].exp_slow, vecs[i].exp_fast);

      for (int r = 0; r < 8; r++) begin
         p  = int'($urandom_range(50, 150));
         lo = WINDOW * p + int'($urandom_range(0, 80)) - 40;
         hi = WINDOW * p + int'($urandom_range(0, 80)) - 40;
         e  = model_count(p);
         run_vec($sformatf("rand%0d", r), p, lo, hi, e, e > hi, e < lo);
      end

      // Ack while nothing is valid is ignored; next result needs a start edge.
      run_vec("pre_ack", 100, 390, 410, 400, 1'b0, 1'b0);
      meas_ack = 1'b1;
      @(negedge clk);
      meas_ack = 1'b0;
      check("stray_ack_valid", 32'(meas_valid), 32'd0);
      check("stray_ack_count", 32'(meas_count), 32'd400);
      wait_valid(800, cyc, ok);
      check("rearm_valid", 32'(ok), 32'd1);
      check("rearm_count", 32'(meas_count), 32'd400);
      check("rearm_latency_in_range", 32'(cyc >= 400 && cyc <= 510), 32'd1);
      ack_and_check("rearm");

      // Drop enable mid-measurement (a 440 result would otherwise appear).
      start_fresh(110, 390, 410);
      repeat (480) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("drop_osc_en", 32'(osc_en),     32'd0);
      check("drop_valid",  32'(meas_valid), 32'd0);
      osc_half = 5000;
      repeat (1000) @(negedge clk);
      check("drop_no_result", 32'(meas_valid), 32'd0);
      check("drop_held_count", 32'(meas_count), 32'd400);
      enable = 1'b1;
      wait_valid(1400, cyc, ok);
      cyc++;
      check("reen_valid", 32'(ok), 32'd1);
      check("reen_count", 32'(meas_count), 32'd400);
      check("reen_full_settle", 32'(cyc >= 600 && cyc <= 708), 32'd1);

      // Asynchronous reset while a result is presented.
      #20;
      reset = 1'b1;
      #1;
      check("async_rst_osc_en", 32'(osc_en),     32'd0);
      check("async_rst_valid",  32'(meas_valid), 32'd0);
      check("async_rst_count",  32'(meas_count), 32'd0);
      check("async_rst_slow",   32'(fault_slow), 32'd0);
      check("async_rst_fast",   32'(fault_fast), 32'd0);
      check("async_rst_dead",   32'(fault_dead), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Stuck-low oscillator: dead fault TIMEOUT cycles after entering SETTLE.
      // Enable is driven at a negedge, so SETTLE starts at the next posedge
      // and the result is first visible TIMEOUT + 1 negedges later.
      osc_run  = 1'b0;
      enable   = 1'b0;
      lo_limit = CNT_W'(390);
      hi_limit = CNT_W'(410);
      repeat (200) @(negedge clk);
      enable = 1'b1;
      wait_valid(TIMEOUT + 200, cyc, ok);
      check("dead_valid",  32'(ok),         32'd1);
      check("dead_cycles", 32'(cyc),        32'(TIMEOUT + 1));
      check("dead_flag",   32'(fault_dead), 32'd1);
      check("dead_count",  32'(meas_count), 32'd0);
      check("dead_slow",   32'(fault_slow), 32'd0);
      check("dead_fast",   32'(fault_fast), 32'd0);
      ack_and_check("dead");
      // Back in ARM with a restarted watchdog.
      wait_valid(TIMEOUT + 200, cyc, ok);
      check("dead2_valid",  32'(ok),         32'd1);
      check("dead2_cycles", 32'(cyc),        32'(TIMEOUT));
      check("dead2_flag",   32'(fault_dead), 32'd1);
      ack_and_check("dead2");

`ifdef RCOSC_FREQ_MONITOR_IRQ_EN
      start_fresh(120, 390, 410);
      wait_valid(1700, cyc, ok);
      check("irq_slow_valid", 32'(ok),  32'd1);
      check("irq_slow_first", 32'(irq), 32'd0);
      @(negedge clk);
      check("irq_slow_rise",  32'(irq), 32'd1);
      ack_and_check("irq_slow");
      check("irq_slow_fall",  32'(irq), 32'd0);
      start_fresh(100, 390, 410);
      wait_valid(1400, cyc, ok);
      check("irq_nom_valid", 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      check("irq_nom_low", 32'(irq), 32'd0);
      ack_and_check("irq_nom");
`endif

      enable = 1'b0;
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rcosc_freq_monitor.md
Name: rcosc_freq_monitor

Overview:
- Consumer of the 100 kHz RC oscillator output; sits directly downstream of the oscillator macro and also drives its EN pin.
- Synchronizes the oscillator clock into the system clock domain and measures system-clock cycles across WINDOW oscillator periods.
- Checks each measurement against programmable limits and flags slow, fast or dead oscillator.
- Presents each result to the housekeeping/CPU side through a valid/ack handshake.

Parameters:
- CNT_W, 24, width of measurement counter, limits and meas_count.
- WINDOW, 4, oscillator periods per measurement (>=1).
- SETTLE_EDGES, 2, rising edges discarded after osc_en asserts.
- TIMEOUT, 4096, clk cycles without a detected edge before dead fault (>=2).
- SYNC_STAGES, 2, synchronizer flops on osc_clk (>=2).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- enable, input, 1, monitor enable; low forces IDLE.
- osc_en, output, 1, drives oscillator EN.
- osc_clk, input, 1, oscillator CLK, asynchronous to clk.
- lo_limit, input, CNT_W, minimum acceptable meas_count.
- hi_limit, input, CNT_W, maximum acceptable meas_count.
- meas_valid, output, 1, result available.
- meas_ack, input, 1, consumer accepts result.
- meas_count, output, CNT_W, clk cycles spanning WINDOW periods.
- fault_slow, output, 1, meas_count > hi_limit.
- fault_fast, output, 1, meas_count < lo_limit.
- fault_dead, output, 1, edge timeout.

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; synchronizer, edge, window, timeout and settle counters cleared.
- Synchronizer and edge detect:
  - osc_clk passes through SYNC_STAGES flops, plus one history flop.
  - Rising-edge pulse "rise" is high one cycle; latency is SYNC_STAGES+1 clk cycles from the osc_clk rising edge.
- States: IDLE, SETTLE, ARM, MEASURE, REPORT.
- IDLE: osc_en=0. Go to SETTLE when enable=1; osc_en=1 from that cycle on.
- SETTLE: count rise pulses. After SETTLE_EDGES of them, go to ARM. If SETTLE_EDGES=0, go to ARM immediately.
- ARM: wait for rise, then go to MEASURE. In that cycle: cycle counter=1, period counter=0.
- MEASURE:
  - Cycle counter increments every clk, saturating at all-ones.
  - Each rise increments the period counter.
  - On the rise that makes the period count equal WINDOW: capture the cycle counter into meas_count (pre-increment value = exact cycles between the two edges), compute faults, go to REPORT.
- Timeout:
  - Active in SETTLE, ARM and MEASURE; cleared on every rise and on entry to SETTLE.
  - After TIMEOUT consecutive cycles with no rise: go to REPORT with meas_count=0, fault_dead=1, fault_slow=0, fault_fast=0.
- Fault compare:
  - Unsigned, done on the captured value.
  - Both fault_fast and fault_slow may be set if lo_limit > hi_limit.
- REPORT:
  - meas_valid=1; meas_count and fault flags are stable and held.
  - meas_ack=1 while meas_valid=1 completes the transfer: the next cycle meas_valid=0 and state goes to ARM. osc_en stays 1; a fresh start edge is required.
  - meas_ack is ignored when meas_valid=0.
- Outputs meas_count/faults keep the last result until the next capture; they are cleared only by reset.
- Oscillator edges arriving during REPORT are ignored; no overrun.
- enable=0 in any state:
  - Next cycle: IDLE, osc_en=0, meas_valid=0.
  - Any in-progress measurement is discarded; held result registers keep their last values.
- Simultaneous rise and timeout terminal count: rise wins; timeout clears.
- Saturation: if the cycle counter saturates, meas_count=all-ones and fault_slow is evaluated normally.

Optional Feature:
- Macro RCOSC_FREQ_MONITOR_IRQ_EN.
- With the macro defined:
  - Adds output port irq (1 bit).
  - irq is registered and rises the cycle after meas_valid rises with any fault flag set.
  - irq falls the cycle after the ack handshake or when enable=0; reset value 0.
- Without the macro: no irq port and no related logic; behaviour otherwise identical.

Test Plan:
- clk 100 ns, osc_clk 10 us square wave, WINDOW=4, lo=390, hi=410, enable=1, ack held 0 -> osc_en=1 next cycle; meas_valid rises after 2 settle + 1 arm + 4 edges; meas_count=400; all faults 0; held until ack.
- Same limits, osc_clk period 12 us -> meas_count=480, fault_slow=1; period 8 us -> meas_count=320, fault_fast=1.
- osc_clk stuck low after enable -> 4096 cycles after entering SETTLE: meas_valid=1, fault_dead=1, meas_count=0; ack -> valid drops next cycle, state ARM, timeout restarts.
- Ack pulse while meas_valid=0 -> no effect. Ack in REPORT -> valid=0 next cycle; next result 400 again after start edge + 4 periods.
- enable dropped mid-MEASURE -> osc_en=0 and meas_valid=0 next cycle; no result. Re-enable -> full settle sequence, result 400. Async reset mid-REPORT -> all outputs 0 immediately.
- With RCOSC_FREQ_MONITOR_IRQ_EN, 12 us period -> irq=1 one cycle after meas_valid; irq=0 the cycle after ack. Nominal 10 us -> irq stays 0.
